// File: rtl/dsi_tx_pixel_reader.sv
// -----------------------------------------------------------------------------
// dsi_tx_pixel_reader
//
// Drain-side reader of the DSI TX pixel FIFO, running in the PHY byte-clock
// domain. When the packet assembler asks for a line, the reader waits until a
// full line is buffered. It then pops exactly W = ceil(LINE_BYTES/4) 32-bit
// words from the show-ahead FIFO and presents them on a registered
// valid/ready stream. The last word carries partial byte strobes.
//
// HS payload cannot stall, so a FIFO underflow mid-line is covered with
// PAD_WORD. Every pad adds one word of "debt". Those late pixels are popped
// and discarded before the next line starts, which keeps later lines aligned.
//
// Ports
//   clk, rst          byte clock, synchronous active-high reset
//   fifo_data         show-ahead FIFO head word
//   fifo_not_empty    FIFO head valid
//   fifo_line_ready   at least one full line buffered
//   fifo_read_ack     pop FIFO head this cycle (combinational)
//   line_start        pulse: request one line payload (ignored unless idle)
//   line_busy         line in progress (state != IDLE)
//   line_done         one-cycle pulse after the last word is accepted
//   pix_data/strb     payload word (byte 0 = bits[7:0], sent first), strobes
//   pix_valid/ready   output handshake
//   pix_last          final word of the line
//   underflow         sticky, set on any pad word, cleared by err_clear
//   err_clear         clears underflow (a simultaneous set wins)
//   state_dbg         current FSM state encoding, for observation
//
// Handshake: a word transfers on a clock edge where pix_valid && pix_ready.
// While pix_valid=1 and pix_ready=0, pix_data/strb/last stay frozen and
// pix_valid does not drop. pix_valid never depends combinationally on
// pix_ready.
// -----------------------------------------------------------------------------
module dsi_tx_pixel_reader #(
    parameter int unsigned LINE_BYTES = 640,
    parameter logic [31:0] PAD_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fifo_data,
    input  logic        fifo_not_empty,
    input  logic        fifo_line_ready,
    output logic        fifo_read_ack,
    input  logic        line_start,
    output logic        line_busy,
    output logic        line_done,
    output logic [31:0] pix_data,
    output logic [3:0]  pix_strb,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        underflow,
    input  logic        err_clear,
    output logic [2:0]  state_dbg
);

    localparam int unsigned WORDS   = (LINE_BYTES + 3) / 4;
    localparam logic [15:0] WORDS_W = 16'(WORDS);
    localparam logic [3:0]  LAST_STRB =
        (LINE_BYTES % 4 == 1) ? 4'b0001 :
        (LINE_BYTES % 4 == 2) ? 4'b0011 :
        (LINE_BYTES % 4 == 3) ? 4'b0111 : 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRAIN     = 3'd1,
        S_WAIT_LINE = 3'd2,
        S_STREAM    = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] fetch_cnt;   // words of the current line still to load
    logic [15:0] debt;        // late words still to discard (saturating)

    logic load;        // output register takes a new word this cycle
    logic load_pad;    // ... and it is a pad word (FIFO empty)
    logic drain_pop;   // discard one late word
    logic last_accept;

    always_comb begin
        load        = (state == S_STREAM) && (!pix_valid || pix_ready) &&
                      (fetch_cnt != 16'd0);
        load_pad    = load && !fifo_not_empty;
        drain_pop   = ((state == S_IDLE) || (state == S_DRAIN)) &&
                      (debt != 16'd0) && fifo_not_empty;
        last_accept = pix_valid && pix_ready && pix_last;

        fifo_read_ack = (load && fifo_not_empty) || drain_pop;
        line_busy     = (state != S_IDLE);
        line_done     = (state == S_FINISH);
        state_dbg     = state;

        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (line_start) begin
                    if (debt != 16'd0)        state_nxt = S_DRAIN;
                    else if (fifo_line_ready) state_nxt = S_STREAM;
                    else                      state_nxt = S_WAIT_LINE;
                end
            end
            S_DRAIN: begin
                // Leave once the debt register shows zero; the head of the
                // FIFO is then the true first pixel of the requested line.
                if (debt == 16'd0)
                    state_nxt = fifo_line_ready ? S_STREAM : S_WAIT_LINE;
            end
            S_WAIT_LINE: begin
                if (fifo_line_ready) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (last_accept) state_nxt = S_FINISH;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fetch_cnt <= 16'd0;
            debt      <= 16'd0;
            pix_valid <= 1'b0;
            pix_data  <= 32'd0;
            pix_strb  <= 4'd0;
            pix_last  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= state_nxt;

            // Re-armed every idle cycle so each line starts with a full count.
            if (state == S_IDLE)
                fetch_cnt <= WORDS_W;
            else if (load)
                fetch_cnt <= fetch_cnt - 16'd1;

            // Drain and pad never coincide: they live in disjoint states.
            if (drain_pop)
                debt <= debt - 16'd1;
            else if (load_pad && (debt != 16'hFFFF))
                debt <= debt + 16'd1;

            if (load) begin
                pix_valid <= 1'b1;
                pix_data  <= fifo_not_empty ? fifo_data : PAD_WORD;
                pix_strb  <= (fetch_cnt == 16'd1) ? LAST_STRB : 4'b1111;
                pix_last  <= (fetch_cnt == 16'd1);
            end else if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end

            if (load_pad)
                underflow <= 1'b1;
            else if (err_clear)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsi_tx_pixel_reader.sv
// -----------------------------------------------------------------------------
// Testbench for dsi_tx_pixel_reader. Two instances: a 640-byte line reader
// (160 words, full strobes) and a 10-byte line reader (3 words, last 0011).
// A queue-based show-ahead FIFO model feeds each instance. Inputs change 1
// time unit after the rising edge; handshakes are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dsi_tx_pixel_reader;

    localparam logic [31:0] PAD = 32'hA5A5_5A5A;

    logic clk;
    logic rst;

    // 640-byte instance
    logic [31:0] fifo_data;
    logic        fifo_not_empty;
    logic        fifo_line_ready;
    logic        fifo_read_ack;
    logic        line_start;
    logic        line_busy;
    logic        line_done;
    logic [31:0] pix_data;
    logic [3:0]  pix_strb;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        underflow;
    logic        err_clear;
    logic [2:0]  state_dbg;

    // 10-byte instance
    logic [31:0] b_fifo_data;
    logic        b_fifo_not_empty;
    logic        b_fifo_line_ready;
    logic        b_fifo_read_ack;
    logic        b_line_start;
    logic        b_line_busy;
    logic        b_line_done;
    logic [31:0] b_pix_data;
    logic [3:0]  b_pix_strb;
    logic        b_pix_valid;
    logic        b_pix_ready;
    logic        b_pix_last;
    logic        b_underflow;
    logic        b_err_clear;
    logic [2:0]  b_state_dbg;

    // FIFO models, accepted-word capture and scoreboard
    logic [31:0] fifo_q[$];
    logic [31:0] b_fifo_q[$];
    logic [31:0] acc_data_q[$];
    logic [3:0]  acc_strb_q[$];
    logic        acc_last_q[$];
    logic [31:0] b_acc_data_q[$];
    logic [3:0]  b_acc_strb_q[$];
    logic        b_acc_last_q[$];
    logic [31:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int ack_count = 0;
    int bad_ack = 0;

    dsi_tx_pixel_reader #(.LINE_BYTES(640), .PAD_WORD(PAD)) u_dut (
        .clk(clk), .rst(rst),
        .fifo_data(fifo_data), .fifo_not_empty(fifo_not_empty),
        .fifo_line_ready(fifo_line_ready), .fifo_read_ack(fifo_read_ack),
        .line_start(line_start), .line_busy(line_busy), .line_done(line_done),
        .pix_data(pix_data), .pix_strb(pix_strb), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_last(pix_last), .underflow(underflow),
        .err_clear(err_clear), .state_dbg(state_dbg)
    );

    dsi_tx_pixel_reader #(.LINE_BYTES(10), .PAD_WORD(PAD)) u_dut10 (
        .clk(clk), .rst(rst),
        .fifo_data(b_fifo_data), .fifo_not_empty(b_fifo_not_empty),
        .fifo_line_ready(b_fifo_line_ready), .fifo_read_ack(b_fifo_read_ack),
        .line_start(b_line_start), .line_busy(b_line_busy), .line_done(b_line_done),
        .pix_data(b_pix_data), .pix_strb(b_pix_strb), .pix_valid(b_pix_valid),
        .pix_ready(b_pix_ready), .pix_last(b_pix_last), .underflow(b_underflow),
        .err_clear(b_err_clear), .state_dbg(b_state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic fifo_refresh();
        fifo_not_empty   = (fifo_q.size() != 0);
        fifo_data        = fifo_not_empty ? fifo_q[0] : 32'hDEAD_BEEF;
        b_fifo_not_empty = (b_fifo_q.size() != 0);
        b_fifo_data      = b_fifo_not_empty ? b_fifo_q[0] : 32'hDEAD_BEEF;
    endtask

    // One clock: sample handshakes on the falling edge, return 1 unit after
    // the rising edge with the FIFO models updated.
    task automatic tick();
        logic ack_s;
        logic b_ack_s;
        @(negedge clk);
        if (pix_valid && pix_ready) begin
            acc_data_q.push_back(pix_data);
            acc_strb_q.push_back(pix_strb);
            acc_last_q.push_back(pix_last);
        end
        if (b_pix_valid && b_pix_ready) begin
            b_acc_data_q.push_back(b_pix_data);
            b_acc_strb_q.push_back(b_pix_strb);
            b_acc_last_q.push_back(b_pix_last);
        end
        ack_s   = fifo_read_ack;
        b_ack_s = b_fifo_read_ack;
        if (ack_s && !fifo_not_empty) bad_ack++;
        if (b_ack_s && !b_fifo_not_empty) bad_ack++;
        @(posedge clk);
        #1;
        if (ack_s) begin
            ack_count++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (b_ack_s && (b_fifo_q.size() != 0)) void'(b_fifo_q.pop_front());
        fifo_refresh();
    endtask

    task automatic clear_capture();
        acc_data_q.delete();
        acc_strb_q.delete();
        acc_last_q.delete();
        exp_q.delete();
    endtask

    task automatic preload(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
        fifo_refresh();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (pix_valid !== 1'b0 || pix_last !== 1'b0 || pix_strb !== 4'd0 || pix_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_pix: got valid=%0b last=%0b strb=%b data=%h, expected 0/0/0000/0",
                     pix_valid, pix_last, pix_strb, pix_data);
        end
        checks++;
        if (fifo_read_ack !== 1'b0 || line_busy !== 1'b0 || line_done !== 1'b0 ||
            underflow !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got ack=%0b busy=%0b done=%0b uf=%0b state=%0d, expected all 0",
                     fifo_read_ack, line_busy, line_done, underflow, state_dbg);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_line();
        int acks0;
        int n;
        int mism;
        clear_capture();
        preload(32'd0, 160);
        for (int i = 0; i < 160; i++) exp_q.push_back(32'(i));
        fifo_line_ready = 1'b1;
        pix_ready       = 1'b1;
        acks0           = ack_count;
        line_start      = 1'b1;
        tick();
        line_start = 1'b0;
        checks++;
        if (pix_valid !== 1'b0 || line_busy !== 1'b1) begin
            errors++;
            $display("FAIL full_latency1: got valid=%0b busy=%0b, expected valid=0 busy=1", pix_valid, line_busy);
        end
        tick();
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== 32'd0) begin
            errors++;
            $display("FAIL full_latency2: got valid=%0b data=%h, expected valid=1 data=0", pix_valid, pix_data);
        end
        n = 0;
        while (!line_done && n < 400) begin
            tick();
            n++;
        end
        // With no bubbles, the 160th acceptance is the edge that raises line_done.
        checks++;
        if (n !== 160) begin
            errors++;
            $display("FAIL full_no_bubbles: got %0d cycles to line_done, expected 160", n);
        end
        mism = 0;
        for (int i = 0; i < acc_data_q.size() && i < exp_q.size(); i++)
            if (acc_data_q[i] !== exp_q[i] || acc_last_q[i] !== (i == 159) || acc_strb_q[i] !== 4'b1111) mism++;
        checks++;
        if (acc_data_q.size() != 160 || mism != 0) begin
            errors++;
            $display("FAIL full_data: got %0d words with %0d bad, expected 160 words 0..159 strb 1111 last on 159",
                     acc_data_q.size(), mism);
        end
        checks++;
        if (underflow !== 1'b0 || (ack_count - acks0) != 160) begin
            errors++;
            $display("FAIL full_ack_uf: got underflow=%0b acks=%0d, expected 0 and 160", underflow, ack_count - acks0);
        end
        tick();
        checks++;
        if (line_done !== 1'b0 || line_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse: got done=%0b busy=%0b, expected 0/0", line_done, line_busy);
        end
    endtask

    task automatic test_short_line();
        int n;
        b_acc_data_q.delete();
        b_acc_strb_q.delete();
        b_acc_last_q.delete();
        b_fifo_q.push_back(32'h1111_1111);
        b_fifo_q.push_back(32'h2222_2222);
        b_fifo_q.push_back(32'h3333_3333);
        fifo_refresh();
        b_line_start = 1'b1;
        tick();
        b_line_start = 1'b0;
        n = 0;
        while (!b_line_done && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (b_acc_data_q.size() != 3) begin
            errors++;
            $display("FAIL short_count: got %0d words, expected 3", b_acc_data_q.size());
        end else begin
            checks++;
            if (b_acc_data_q[0] !== 32'h1111_1111 || b_acc_data_q[1] !== 32'h2222_2222 ||
                b_acc_data_q[2] !== 32'h3333_3333) begin
                errors++;
                $display("FAIL short_data: got %h %h %h, expected 11111111 22222222 33333333",
                         b_acc_data_q[0], b_acc_data_q[1], b_acc_data_q[2]);
            end
            checks++;
            if (b_acc_strb_q[0] !== 4'b1111 || b_acc_strb_q[1] !== 4'b1111 || b_acc_strb_q[2] !== 4'b0011 ||
                b_acc_last_q[0] !== 1'b0 || b_acc_last_q[1] !== 1'b0 || b_acc_last_q[2] !== 1'b1) begin
                errors++;
                $display("FAIL short_strb_last: got strb %b %b %b last %0b%0b%0b, expected 1111 1111 0011 last 001",
                         b_acc_strb_q[0], b_acc_strb_q[1], b_acc_strb_q[2],
                         b_acc_last_q[0], b_acc_last_q[1], b_acc_last_q[2]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int acks0;
        int n;
        int mism;
        int hold_err;
        logic        p_valid;
        logic        p_ready;
        logic [31:0] p_data;
        logic [3:0]  p_strb;
        logic        p_last;
        clear_capture();
        preload(32'd1000, 160);
        for (int i = 0; i < 160; i++) exp_q.push_back(32'd1000 + 32'(i));
        acks0      = ack_count;
        hold_err   = 0;
        line_start = 1'b1;
        pix_ready  = 1'($urandom_range(0, 1));
        tick();
        line_start = 1'b0;
        n = 0;
        while (!line_done && n < 2000) begin
            pix_ready = 1'($urandom_range(0, 1));
            p_valid = pix_valid;
            p_ready = pix_ready;
            p_data  = pix_data;
            p_strb  = pix_strb;
            p_last  = pix_last;
            tick();
            n++;
            if (p_valid && !p_ready &&
                (pix_valid !== 1'b1 || pix_data !== p_data || pix_strb !== p_strb || pix_last !== p_last))
                hold_err++;
        end
        pix_ready = 1'b1;
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d stalled cycles with changed output, expected 0", hold_err);
        end
        mism = 0;
        for (int i = 0; i < acc_data_q.size() && i < exp_q.size(); i++)
            if (acc_data_q[i] !== exp_q[i]) mism++;
        checks++;
        if (acc_data_q.size() != 160 || mism != 0) begin
            errors++;
            $display("FAIL bp_data: got %0d words with %0d bad, expected 160 words 1000..1159",
                     acc_data_q.size(), mism);
        end
        checks++;
        if ((ack_count - acks0) != 160 || bad_ack != 0) begin
            errors++;
            $display("FAIL bp_acks: got acks=%0d bad_acks=%0d, expected 160 and 0", ack_count - acks0, bad_ack);
        end
        tick();
    endtask

    task automatic test_underflow();
        int acks0;
        int n;
        int mism;
        clear_capture();
        preload(32'd2000, 100);
        for (int i = 0; i < 100; i++) exp_q.push_back(32'd2000 + 32'(i));
        for (int i = 0; i < 60; i++) exp_q.push_back(PAD);
        pix_ready  = 1'b1;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        n = 0;
        while (!line_done && n < 400) begin
            tick();
            n++;
        end
        mism = 0;
        for (int i = 0; i < acc_data_q.size() && i < exp_q.size(); i++)
            if (acc_data_q[i] !== exp_q[i] || acc_strb_q[i] !== 4'b1111 || acc_last_q[i] !== (i == 159)) mism++;
        checks++;
        if (acc_data_q.size() != 160 || mism != 0) begin
            errors++;
            $display("FAIL uf_data: got %0d words with %0d bad, expected 2000..2099 then 60 pads",
                     acc_data_q.size(), mism);
        end
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_flag: got %0b, expected 1", underflow);
        end
        tick();
        // 30 late words drain while idle
        acks0 = ack_count;
        preload(32'd3000, 30);
        repeat (40) tick();
        checks++;
        if ((ack_count - acks0) != 30 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL uf_idle_drain: got acks=%0d left=%0d, expected 30 and 0", ack_count - acks0, fifo_q.size());
        end
        // 30 more late words then a real line, requested while still in debt
        preload(32'd3030, 30);
        preload(32'd4000, 160);
        clear_capture();
        for (int i = 0; i < 160; i++) exp_q.push_back(32'd4000 + 32'(i));
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        checks++;
        if (state_dbg !== 3'd1) begin
            errors++;
            $display("FAIL uf_drain_state: got %0d, expected 1 (DRAIN)", state_dbg);
        end
        n = 0;
        while (!line_done && n < 600) begin
            tick();
            n++;
        end
        mism = 0;
        for (int i = 0; i < acc_data_q.size() && i < exp_q.size(); i++)
            if (acc_data_q[i] !== exp_q[i]) mism++;
        checks++;
        if (acc_data_q.size() != 160 || mism != 0 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL uf_realign: got %0d words with %0d bad (first %h), fifo left %0d, expected 4000..4159 and 0",
                     acc_data_q.size(), mism, (acc_data_q.size() != 0) ? acc_data_q[0] : 32'hFFFF_FFFF, fifo_q.size());
        end
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_sticky: got %0b, expected 1", underflow);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_clear: got %0b, expected 0", underflow);
        end
        tick();
    endtask

    task automatic test_wait_line();
        int acks0;
        int n;
        int mism;
        clear_capture();
        preload(32'd5000, 160);
        for (int i = 0; i < 160; i++) exp_q.push_back(32'd5000 + 32'(i));
        fifo_line_ready = 1'b0;
        line_start      = 1'b1;
        tick();
        line_start = 1'b0;
        acks0 = ack_count;
        repeat (20) tick();
        checks++;
        if (state_dbg !== 3'd2 || (ack_count - acks0) != 0 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: got state=%0d acks=%0d valid=%0b, expected 2/0/0",
                     state_dbg, ack_count - acks0, pix_valid);
        end
        fifo_line_ready = 1'b1;
        tick();
        checks++;
        if (state_dbg !== 3'd3 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_to_stream: got state=%0d valid=%0b, expected 3/0", state_dbg, pix_valid);
        end
        tick();
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== 32'd5000) begin
            errors++;
            $display("FAIL wait_first_word: got valid=%0b data=%0d, expected 1/5000", pix_valid, pix_data);
        end
        n = 0;
        while (!line_done && n < 400) begin
            tick();
            n++;
        end
        mism = 0;
        for (int i = 0; i < acc_data_q.size() && i < exp_q.size(); i++)
            if (acc_data_q[i] !== exp_q[i]) mism++;
        checks++;
        if (acc_data_q.size() != 160 || mism != 0) begin
            errors++;
            $display("FAIL wait_data: got %0d words with %0d bad, expected 5000..5159", acc_data_q.size(), mism);
        end
        tick();
    endtask

    task automatic test_reset_mid_line();
        int n;
        int mism;
        clear_capture();
        preload(32'd6000, 160);
        for (int i = 0; i < 50; i++) exp_q.push_back(32'd6000 + 32'(i));
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        n = 0;
        while (acc_data_q.size() < 20 && n < 100) begin
            tick();
            n++;
        end
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        checks++;
        if (state_dbg !== 3'd3 || line_busy !== 1'b1) begin
            errors++;
            $display("FAIL extra_start: got state=%0d busy=%0b, expected 3/1", state_dbg, line_busy);
        end
        n = 0;
        while (acc_data_q.size() < 50 && n < 100) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if (pix_valid !== 1'b0 || pix_last !== 1'b0 || pix_strb !== 4'd0 || pix_data !== 32'd0 ||
            fifo_read_ack !== 1'b0 || line_busy !== 1'b0 || line_done !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL midline_reset: got valid=%0b last=%0b strb=%b data=%h ack=%0b busy=%0b done=%0b state=%0d, expected all 0",
                     pix_valid, pix_last, pix_strb, pix_data, fifo_read_ack, line_busy, line_done, state_dbg);
        end
        rst = 1'b0;
        mism = 0;
        for (int i = 0; i < 50 && i < acc_data_q.size(); i++)
            if (acc_data_q[i] !== exp_q[i]) mism++;
        checks++;
        if (acc_data_q.size() < 50 || mism != 0) begin
            errors++;
            $display("FAIL midline_data: got %0d words with %0d bad, expected 6000..6049 in order",
                     acc_data_q.size(), mism);
        end
        fifo_q.delete();
        fifo_refresh();
        tick();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst               = 1'b1;
        line_start        = 1'b0;
        pix_ready         = 1'b1;
        fifo_line_ready   = 1'b1;
        err_clear         = 1'b0;
        b_line_start      = 1'b0;
        b_pix_ready       = 1'b1;
        b_fifo_line_ready = 1'b1;
        b_err_clear       = 1'b0;
        fifo_refresh();

        test_reset();
        test_full_line();
        test_short_line();
        test_backpressure();
        test_underflow();
        test_wait_line();
        test_reset_mid_line();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
